pipe_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It merges the load-use hazard request, the ID-stage branch decision, multi-cycle data-memory accesses and the multi-cycle MUL/DIV unit into one coherent set of per-stage write enables, bubbles and flushes. It replaces the ad-hoc wiring of stall signals in the CPU top level.

---
 rtl/pipe_stall_ctrl.sv | 74 +++++++
 tb/tb_pipe_stall_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges memory/MDU/load-use/branch hazards into per-stage enables; PIPE_STALL_CTRL_PERF_EN adds perf counters
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hazard_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ack_i,
  input  logic        mdu_start_i,
  input  logic        mdu_done_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_write_o,
  output logic        idex_bubble_o,
  output logic        exmem_write_o,
  output logic        memwb_bubble_o,
  output logic        err_o
`ifdef PIPE_STALL_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] mdu_cnt_o
`endif
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, MDU_WAIT} state_t;
  localparam logic [9:0] TMO = 10'(MEM_TIMEOUT);
  state_t state, state_nxt;
  logic [9:0] cnt, cnt_nxt;
  logic mem_stall, mdu_stall, freeze;
  // decode: memory stall outranks MDU, which outranks load-use, which outranks branch flush
  always_comb begin
    mem_stall = state == RUN ? dmem_req_i && !dmem_ack_i : state == MEM_WAIT ? !dmem_ack_i : 1'b0;
    mdu_stall = !mdu_done_i && (state == MDU_WAIT || mdu_start_i);
    freeze = mem_stall || mdu_stall;
    pc_write_o = !rst_i && !freeze && !hazard_i;
    ifid_write_o = !rst_i && !freeze && !hazard_i;
    ifid_flush_o = !rst_i && !freeze && !hazard_i && branch_taken_i;
    idex_write_o = !rst_i && !freeze;
    exmem_write_o = !rst_i && !freeze;
    idex_bubble_o = rst_i || (!freeze && hazard_i);
    memwb_bubble_o = rst_i || freeze;
    state_nxt = mem_stall ? MEM_WAIT : mdu_stall ? MDU_WAIT : RUN;
    cnt_nxt = state != MEM_WAIT ? 10'd0 : (!dmem_ack_i && cnt != TMO) ? cnt + 10'd1 : cnt;
  end
  // state, saturating wait counter and sticky timeout flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
      cnt <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      err_o <= err_o || cnt_nxt == TMO;
    end
  end
`ifdef PIPE_STALL_CTRL_PERF_EN
  // free-running event counters, wrapping at 2^32
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      mdu_cnt_o <= '0;
    end else begin
      stall_cnt_o <= stall_cnt_o + 32'(!pc_write_o);
      flush_cnt_o <= flush_cnt_o + 32'(ifid_flush_o);
      mdu_cnt_o <= mdu_cnt_o + 32'(state == MDU_WAIT);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: scoreboard bench for pipe_stall_ctrl with MEM_TIMEOUT=8
module tb_pipe_stall_ctrl;
  logic clk = 0, rst = 1, hazard = 0, branch = 0, req = 0, ack = 0, ms = 0, md = 0;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble, err;
`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, mdu_cnt;
`endif
  int checks = 0, errors = 0;
  logic [7:0] sb[$];
  localparam logic [6:0] I0 = 7'b0000000, R = 7'b1000000, H = 7'b0100000, B = 7'b0010000,
                         Q = 7'b0001000, A = 7'b0000100, S = 7'b0000010, D = 7'b0000001;
  localparam logic [6:0] FREE = 7'b1101010, FRZ = 7'b0000001, HAZ = 7'b0001110,
                         BR = 7'b1111010, RSTV = 7'b0000101;
  pipe_stall_ctrl #(.MEM_TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst), .hazard_i(hazard), .branch_taken_i(branch),
    .dmem_req_i(req), .dmem_ack_i(ack), .mdu_start_i(ms), .mdu_done_i(md),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .idex_write_o(idex_write), .idex_bubble_o(idex_bubble), .exmem_write_o(exmem_write),
    .memwb_bubble_o(memwb_bubble), .err_o(err)
`ifdef PIPE_STALL_CTRL_PERF_EN
    , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .mdu_cnt_o(mdu_cnt)
`endif
  );
  always #5 clk = ~clk;
  wire [7:0] obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble, err};
  task automatic drive(input logic [14:0] row);
    {rst, hazard, branch, req, ack, ms, md} = row[14:8];
    sb.push_back(row[7:0]);
  endtask
  task automatic test_reset();
    logic [14:0] t[$];
    logic [7:0] exp;
    t.push_back({R, RSTV, 1'b0});
    t.push_back({R | Q | H, RSTV, 1'b0});
    t.push_back({I0, FREE, 1'b0});
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset row %0d: got %b expected %b", i, obs, exp); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_load_use();
    logic [14:0] t[$];
    logic [7:0] exp;
    t.push_back({H, HAZ, 1'b0});
    t.push_back({I0, FREE, 1'b0});
    t.push_back({H | B, HAZ, 1'b0});
    t.push_back({B, BR, 1'b0});
    t.push_back({D, FREE, 1'b0});
    t.push_back({A, FREE, 1'b0});
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL load_use row %0d: got %b expected %b", i, obs, exp); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_mem_wait();
    logic [14:0] t[$];
    logic [7:0] exp;
    t.push_back({Q, FRZ, 1'b0});
    t.push_back({Q | H, FRZ, 1'b0});
    t.push_back({Q | B, FRZ, 1'b0});
    t.push_back({Q | A, FREE, 1'b0});
    t.push_back({I0, FREE, 1'b0});
    t.push_back({Q | A, FREE, 1'b0});
    t.push_back({Q, FRZ, 1'b0});
    t.push_back({Q | A | H | B, HAZ, 1'b0});
    t.push_back({Q, FRZ, 1'b0});
    t.push_back({Q | A | B, BR, 1'b0});
    t.push_back({Q, FRZ, 1'b0});
    t.push_back({Q | A | S, FRZ, 1'b0});
    t.push_back({Q | A, FRZ, 1'b0});
    t.push_back({Q | D, FREE, 1'b0});
    t.push_back({I0, FREE, 1'b0});
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mem_wait row %0d: got %b expected %b", i, obs, exp); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_mdu_branch();
    logic [14:0] t[$];
    logic [7:0] exp;
    t.push_back({S | B, FRZ, 1'b0});
    for (int k = 0; k < 4; k++) t.push_back({B | H, FRZ, 1'b0});
    t.push_back({D | B, BR, 1'b0});
    t.push_back({I0, FREE, 1'b0});
    t.push_back({S | D, FREE, 1'b0});
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mdu_branch row %0d: got %b expected %b", i, obs, exp); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_timeout();
    logic [14:0] t[$];
    logic [7:0] exp;
    for (int k = 0; k < 5; k++) t.push_back({Q, FRZ, 1'b0});
    t.push_back({R | Q, RSTV, 1'b0});
    t.push_back({I0, FREE, 1'b0});
    for (int k = 0; k < 9; k++) t.push_back({Q, FRZ, 1'b0});
    t.push_back({Q, FRZ, 1'b1});
    t.push_back({Q | H, FRZ, 1'b1});
    t.push_back({R, RSTV, 1'b1});
    t.push_back({I0, FREE, 1'b0});
    t.push_back({B, BR, 1'b0});
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL timeout row %0d: got %b expected %b", i, obs, exp); end
      @(posedge clk); #1;
    end
  endtask
`ifdef PIPE_STALL_CTRL_PERF_EN
  task automatic test_perf();
    logic [14:0] t[$];
    logic [7:0] exp;
    t.push_back({R, RSTV, 1'b0});
    for (int k = 0; k < 3; k++) t.push_back({Q, FRZ, 1'b0});
    t.push_back({Q | A, FREE, 1'b0});
    t.push_back({B, BR, 1'b0});
    t.push_back({I0, FREE, 1'b0});
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL perf row %0d: got %b expected %b", i, obs, exp); end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt); end
    checks++;
    if (flush_cnt !== 32'd1) begin errors++; $display("FAIL flush_cnt: got %0d expected 1", flush_cnt); end
    checks++;
    if (mdu_cnt !== 32'd0) begin errors++; $display("FAIL mdu_cnt: got %0d expected 0", mdu_cnt); end
  endtask
`endif
  initial begin
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_mdu_branch();
    test_timeout();
`ifdef PIPE_STALL_CTRL_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
